// File: rtl/seq_alu_exec.sv
// rtl/seq_alu_exec.sv - multi-cycle ALU execution unit with bit-serial shifter and start/done handshake
module seq_alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUConf,
  input  logic             Sign,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_SLT    = 5'b00111;
  localparam logic [4:0] OP_NOR    = 5'b01100;
  localparam logic [4:0] OP_XOR    = 5'b01101;
  localparam logic [4:0] OP_SRL    = 5'b10000;
  localparam logic [4:0] OP_SRA    = 5'b11000;
  localparam logic [4:0] OP_SLL    = 5'b11001;
  localparam logic [4:0] OP_SUBSET = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SRL = 2'd0,
    SH_SRA = 2'd1,
    SH_SLL = 2'd2
  } shift_t;

  state_t           state;
  shift_t           shift_kind;
  shift_t           shift_kind_in;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [4:0]       shift_cnt;
  logic [WIDTH-1:0] alu_res;
  logic             is_shift;
  logic             lt_signed;
  logic             lt_unsigned;

  // Single-cycle ops, evaluated straight from the inputs so the result is captured on the accepting edge
  always_comb begin
    lt_signed   = $signed(In1) < $signed(In2);
    lt_unsigned = In1 < In2;
    alu_res     = In1 + In2;
    case (ALUConf)
      OP_ADD:    alu_res = In1 + In2;
      OP_OR:     alu_res = In1 | In2;
      OP_AND:    alu_res = In1 & In2;
      OP_SUB:    alu_res = In1 - In2;
      OP_SLT:    alu_res = {{(WIDTH-1){1'b0}}, (Sign ? lt_signed : lt_unsigned)};
      OP_NOR:    alu_res = ~(In1 | In2);
      OP_XOR:    alu_res = In1 ^ In2;
      OP_SUBSET: alu_res = {{(WIDTH-1){1'b0}}, ((In1 & ~In2) == '0)};
      default:   alu_res = In1 + In2;
    endcase
  end

  // Decode whether the requested op goes through the serial shifter, and which direction
  always_comb begin
    is_shift      = 1'b0;
    shift_kind_in = SH_SRL;
    case (ALUConf)
      OP_SRL: begin
        is_shift      = 1'b1;
        shift_kind_in = SH_SRL;
      end
      OP_SRA: begin
        is_shift      = 1'b1;
        shift_kind_in = SH_SRA;
      end
      OP_SLL: begin
        is_shift      = 1'b1;
        shift_kind_in = SH_SLL;
      end
      default: begin
        is_shift      = 1'b0;
        shift_kind_in = SH_SRL;
      end
    endcase
  end

  // One-position shift of the held operand; SRA replicates the sign bit on every step
  always_comb begin
    shift_next = shift_reg;
    case (shift_kind)
      SH_SRL:  shift_next = {1'b0, shift_reg[WIDTH-1:1]};
      SH_SRA:  shift_next = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
      SH_SLL:  shift_next = {shift_reg[WIDTH-2:0], 1'b0};
      default: shift_next = shift_reg;
    endcase
  end

  // Control FSM with registered busy/done/Result/Zero; start is only honoured in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      Result     <= '0;
      Zero       <= 1'b1;
      shift_reg  <= '0;
      shift_cnt  <= '0;
      shift_kind <= SH_SRL;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (is_shift) begin
              shift_reg  <= In2;
              shift_cnt  <= In1[4:0];
              shift_kind <= shift_kind_in;
              if (In1[4:0] == 5'd0) begin
                // Zero shift amount completes immediately with the operand unchanged
                Result <= In2;
                Zero   <= (In2 == '0);
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                state <= SHIFT;
              end
            end else begin
              Result <= alu_res;
              Zero   <= (alu_res == '0);
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          busy      <= 1'b1;
          shift_reg <= shift_next;
          shift_cnt <= shift_cnt - 5'd1;
          if (shift_cnt == 5'd1) begin
            Result <= shift_next;
            Zero   <= (shift_next == '0);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_exec.sv
// tb/tb_seq_alu_exec.sv - directed self-checking bench for seq_alu_exec
module tb_seq_alu_exec;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  ALUConf;
  logic        Sign;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic        Zero;

  int checks;
  int errors;

  seq_alu_exec #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ALUConf (ALUConf),
    .Sign    (Sign),
    .In1     (In1),
    .In2     (In2),
    .busy    (busy),
    .done    (done),
    .Result  (Result),
    .Zero    (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for done with a cycle budget; lat counts cycles after the accepting edge
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 64) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] conf, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res);
    int lat;
    ALUConf = conf;
    Sign    = sgn;
    In1     = a;
    In2     = b;
    start   = 1'b1;
    step();
    start   = 1'b0;
    In1     = $urandom;
    In2     = $urandom;
    ALUConf = 5'b11001;
    Sign    = ~sgn;
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, Result, exp_res);
    check({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp_res == 32'd0)});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, Result, exp_res);
  endtask

  initial begin
    int lat;
    int done_cnt;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    ALUConf = 5'd0;
    Sign    = 1'b0;
    In1     = 32'd0;
    In2     = 32'd0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd1);

    // ADD overflow wraps; busy low in the start cycle
    ALUConf = 5'b00000;
    In1     = 32'h7FFF_FFFF;
    In2     = 32'h0000_0001;
    start   = 1'b1;
    check("add_busy_t", {31'd0, busy}, 32'd0);
    step();
    start = 1'b0;
    check("add_done_t1", {31'd0, done}, 32'd1);
    check("add_busy_t1", {31'd0, busy}, 32'd1);
    check("add_res", Result, 32'h8000_0000);
    check("add_zero", {31'd0, Zero}, 32'd0);
    step();
    check("add_done_t2", {31'd0, done}, 32'd0);
    check("add_busy_t2", {31'd0, busy}, 32'd0);

    run_op("sub_eq",     5'b00110, 1'b0, 32'h0000_1234, 32'h0000_1234, 1, 32'd0);
    run_op("slt_signed", 5'b00111, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'd1);
    run_op("slt_unsign", 5'b00111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'd0);
    run_op("or",         5'b00001, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 1, 32'hF0F0_0F0F);
    run_op("and",        5'b00010, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00);
    run_op("nor",        5'b01100, 1'b0, 32'hFFFF_0000, 32'h0000_00FF, 1, 32'h0000_FF00);
    run_op("xor",        5'b01101, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 1, 32'h5555_5555);
    run_op("unknown",    5'b01010, 1'b0, 32'd3, 32'd4, 1, 32'd7);
    run_op("subset_yes", 5'b11111, 1'b0, 32'h5, 32'hF, 1, 32'd1);
    run_op("subset_no",  5'b11111, 1'b0, 32'h10, 32'hF, 1, 32'd0);
    run_op("sll_zero",   5'b11001, 1'b0, 32'd0, 32'h0000_ABCD, 1, 32'h0000_ABCD);
    run_op("srl_31",     5'b10000, 1'b0, 32'd31, 32'h8000_0000, 32, 32'd1);
    run_op("sll_4",      5'b11001, 1'b0, 32'd4, 32'h8000_0011, 5, 32'h0000_0110);
    run_op("srl_zero_res", 5'b10000, 1'b0, 32'd1, 32'h0000_0001, 2, 32'd0);

    // SRA with a second start during SHIFT that must be ignored
    ALUConf = 5'b11000;
    In1     = 32'd4;
    In2     = 32'h8000_0010;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    check("sra_busy_shift", {31'd0, busy}, 32'd1);
    ALUConf = 5'b00000;
    In1     = 32'd1;
    In2     = 32'd1;
    start   = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    wait_done(lat);
    check("sra_lat", lat + 2, 32'd5);
    check("sra_res", Result, 32'hF800_0001);
    step();
    check("sra_no_requeue", {31'd0, done | busy}, 32'd0);
    run_op("after_sra", 5'b00000, 1'b0, 32'd3, 32'd4, 1, 32'd7);

    // Reset in the middle of an SLL by 20 aborts it without a done pulse
    ALUConf = 5'b11001;
    In1     = 32'd20;
    In2     = 32'h0000_0001;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", Result, 32'd0);
    check("abort_zero", {31'd0, Zero}, 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) done_cnt++;
      step();
    end
    check("abort_no_done", done_cnt, 32'd0);

    // Reset and start together: start is dropped
    ALUConf = 5'b00000;
    In1     = 32'd5;
    In2     = 32'd6;
    start   = 1'b1;
    reset   = 1'b1;
    step();
    start = 1'b0;
    reset = 1'b0;
    step();
    check("rst_start_done", {31'd0, done | busy}, 32'd0);
    check("rst_start_res", Result, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu_exec.md
Name: seq_alu_exec

Overview:
- Execution unit at the consuming end of the ALU control path in the multi-cycle CPU.
- Accepts the 5-bit ALU configuration code and the Sign flag produced by ALU control, plus two 32-bit operands.
- Produces a registered result and a Zero flag using a start/done handshake.
- Logic ops and arithmetic complete in one cycle. Shifts run bit-serially, one position per cycle, to keep the datapath small; the multi-cycle FSM waits on done.

Parameters:
- WIDTH, 32: operand and result width. Shift amount is taken from In1[4:0]; only WIDTH=32 is supported.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- ALUConf  input  5  operation code, sampled with start.
- Sign  input  1  1 = signed compare for SLT, 0 = unsigned; sampled with start.
- In1  input  WIDTH  operand A; shift amount in In1[4:0] for shift ops.
- In2  input  WIDTH  operand B; the value shifted for shift ops.
- busy  output  1  high from the cycle after an accepted start until the cycle done is high (inclusive).
- done  output  1  single-cycle pulse; Result and Zero are valid from this cycle on.
- Result  output  WIDTH  registered result, held until the next accepted start completes.
- Zero  output  1  registered, equals (Result == 0).

Behaviour:
- Opcodes: ADD 00000, OR 00001, AND 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SRL 10000, SRA 11000, SLL 11001, SUBSET 11111.
- Any other code executes as ADD.
- ADD/SUB: modulo 2^WIDTH; no overflow detection.
- SLT: Result = 1 if In1 < In2, else 0. Compare is two's complement when Sign=1, unsigned when Sign=0.
- SUBSET: Result = 1 if (In1 & ~In2) == 0, else 0.
- SLL/SRL/SRA shift In2 by In1[4:0]. SRL fills zeros; SRA replicates In2[31].
- Operands, code and Sign are latched on the accepted start. Later input changes have no effect on the operation in progress.
- Reset: state IDLE; busy=0, done=0, Result=0, Zero=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 with a non-shift op: compute, register Result/Zero, go to DONE.
  - start=1 with a shift op: load the shift register with In2 and the counter with In1[4:0]. Go to SHIFT if the count is non-zero; otherwise go to DONE with Result=In2.
- SHIFT: each cycle, shift the register by 1 position and decrement the counter. When the counter reaches 1, that cycle's shifted value goes to Result and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is accepted in IDLE only, including the cycle after DONE.
- Latency, with start accepted at cycle t:
  - Non-shift op: done at t+1.
  - Shift op: done at t+1+shamt; shamt=31 gives done at t+32.
- busy:
  - High in SHIFT and DONE, and also in the single-cycle DONE of non-shift ops.
  - start while busy=1 is ignored and not queued.
- Zero is updated in the same cycle as Result and never changes except when done is asserted.
- Reset mid-operation (any state) aborts the op next edge and forces the reset values above. No done pulse is produced for the aborted op.
- Reset and start in the same cycle: reset wins and start is dropped.

Test Plan:
- Reset, then ADD: In1=0x7FFFFFFF, In2=1, start at t -> done at t+1, Result=0x80000000, Zero=0; busy=1 only at t+1.
- SUB equal: In1=In2=0x1234 -> Result=0, Zero=1. SLT with In1=0xFFFFFFFF, In2=1: Sign=1 -> Result=1; Sign=0 -> Result=0.
- SRA: In1=4, In2=0x80000010 -> done at t+5, Result=0xF8000001. SLL with shamt=0, In2=0xABCD -> done at t+1, Result=0xABCD. SRL with shamt=31, In2=0x80000000 -> done at t+32, Result=1.
- start pulsed again during SHIFT with a different op -> ignored; the first result is unchanged; a new start in the cycle after done is accepted and completes normally.
- Assert reset during SHIFT of an SLL by 20 -> next cycle busy=0, Result=0, Zero=1, and no done pulse follows.
- Unknown code 01010 with In1=3, In2=4 -> Result=7. SUBSET with In1=0x5, In2=0xF -> Result=1; SUBSET with In1=0x10, In2=0xF -> Result=0.
